// File: rtl/lsu_sram_if_pkg.sv
// Shared definitions for the LSU-to-SRAM bridge: RISC-V funct3 codes,
// SRAM byte-strobe patterns, FSM state encoding and small decode helpers.
package lsu_sram_if_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] WEN_NONE = 4'b0000;
  localparam logic [3:0] WEN_B    = 4'b0001;
  localparam logic [3:0] WEN_H    = 4'b0011;
  localparam logic [3:0] WEN_W    = 4'b1111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  // Store strobe for a funct3 code; loads never reach this decode.
  function automatic logic [3:0] f3_strobe(input logic [2:0] funct3);
    logic [3:0] wen;
    wen = WEN_NONE;
    case (funct3)
      F3_B:    wen = WEN_B;
      F3_H:    wen = WEN_H;
      F3_W:    wen = WEN_W;
      default: wen = WEN_NONE;
    endcase
    return wen;
  endfunction

  function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // funct3[1:0] carries the access size for every legal code (00 byte, 01 half, 10 word).
  function automatic logic f3_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (funct3[1:0])
      2'b01:   mis = addr_lo[0];
      2'b10:   mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_sram_if_load_ext.sv
// Load-data extension: selects byte/halfword/word from the little-endian
// SRAM read word and sign- or zero-extends it according to funct3.
module lsu_load_ext
  import lsu_sram_if_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  always_comb begin
    ext = raw;
    case (funct3)
      F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
      F3_BU:   ext = {24'd0, raw[7:0]};
      F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
      F3_HU:   ext = {16'd0, raw[15:0]};
      F3_W:    ext = raw;
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/lsu_sram_if.sv
// Single-outstanding load/store unit in front of a byte-addressed SRAM:
// IDLE accepts, ACCESS drives the SRAM for one cycle, RESP holds the result.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high. req_ready depends on state only; once rsp_valid rises, rsp_rdata and
// rsp_fault hold until the rsp_valid & rsp_ready edge.
module lsu_sram_if
  import lsu_sram_if_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic [3:0]        mem_w_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  lsu_state_e        state_q, state_d;

  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              fault_q;
  logic [3:0]        wen_q;
  logic [31:0]       rdata_q;
  logic              rsp_fault_q;

  logic              accept;
  logic              range_fault;
  logic              req_fault;
  logic [31:0]       load_ext;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid & req_ready;

  // Shift form stays legal even if ADDR_W is raised to 32.
  assign range_fault = ((req_addr >> ADDR_W) != 32'd0);
  assign req_fault   = range_fault
                     | ~f3_legal(req_we, req_funct3)
                     | (CHECK_ALIGN & f3_misaligned(req_funct3, req_addr[1:0]));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request capture; the address/data registers double as the held SRAM outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      fault_q  <= 1'b0;
    end else if (accept) begin
      we_q     <= req_we;
      funct3_q <= req_funct3;
      addr_q   <= req_addr[ADDR_W-1:0];
      wdata_q  <= req_wdata;
      fault_q  <= req_fault;
    end
  end

  // Strobe is a flop set by the accept edge and cleared by the next one, so it
  // is high for exactly the ACCESS cycle and cannot glitch in IDLE or RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q <= WEN_NONE;
    end else if (accept && req_we && !req_fault) begin
      wen_q <= f3_strobe(req_funct3);
    end else begin
      wen_q <= WEN_NONE;
    end
  end

  lsu_load_ext u_load_ext (
    .funct3 (funct3_q),
    .raw    (mem_read_data),
    .ext    (load_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q     <= 32'd0;
      rsp_fault_q <= 1'b0;
    end else if (state_q == ACCESS) begin
      rdata_q     <= (!we_q && !fault_q) ? load_ext : 32'd0;
      rsp_fault_q <= fault_q;
    end
  end

  assign rsp_valid      = (state_q == RESP);
  assign rsp_rdata      = rdata_q;
  assign rsp_fault      = rsp_fault_q;
  assign mem_w_en       = wen_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;

endmodule

// File: tb/tb_lsu_sram_if.sv
// Bench for lsu_sram_if: byte-array SRAM model on the memory port, a
// spec-level reference model of memory contents, directed and random tests.
module tb_lsu_sram_if;

  localparam int ADDR_W      = 16;
  localparam bit CHECK_ALIGN = 1'b1;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_fault;
  logic [3:0]        mem_w_en;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;

  int n_cmp;
  int n_fail;

  logic [7:0] sram    [0:65535];
  logic [7:0] ref_mem [0:65535];

  lsu_sram_if #(.ADDR_W(ADDR_W), .CHECK_ALIGN(CHECK_ALIGN)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_fault      (rsp_fault),
    .mem_w_en       (mem_w_en),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- SRAM model (wraps modulo 2^16) ----------------
  always_comb begin
    mem_read_data = {sram[mem_address + 16'd3], sram[mem_address + 16'd2],
                     sram[mem_address + 16'd1], sram[mem_address]};
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_w_en[i]) sram[mem_address + 16'(i)] <= mem_write_data[8*i +: 8];
  end

  // ---------------- reference model ----------------
  task automatic model_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic exp_fault,
                           output logic [31:0] exp_rdata, output logic [3:0] exp_wen);
    int nbytes;
    logic legal, mis;
    logic [31:0] b [4];
    logic [31:0] v;
    nbytes = (f3 == 3'd2) ? 4 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 1);
    legal  = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    mis    = CHECK_ALIGN && ((addr % nbytes) != 0);
    exp_fault = (64'(addr) >= (64'd1 << ADDR_W)) || !legal || mis;
    exp_rdata = 32'd0;
    exp_wen   = 4'd0;
    if (exp_fault) return;
    if (we) begin
      for (int i = 0; i < nbytes; i++)
        ref_mem[16'(addr[15:0] + 16'(i))] = 8'(wdata >> (8 * i));
      exp_wen = 4'((1 << nbytes) - 1);
    end else begin
      for (int i = 0; i < 4; i++) b[i] = 32'(ref_mem[16'(addr[15:0] + 16'(i))]);
      case (f3)
        3'd0: begin v = b[0]; if (v >= 32'd128) v = v - 32'd256; end
        3'd4: v = b[0];
        3'd1: begin v = b[0] + 32'd256 * b[1]; if (v >= 32'd32768) v = v - 32'd65536; end
        3'd5: v = b[0] + 32'd256 * b[1];
        default: v = b[0] + (b[1] << 8) + (b[2] << 16) + (b[3] << 24);
      endcase
      exp_rdata = v;
    end
  endtask

  // ---------------- driver ----------------
  // Issues one request, then observes cycles after the accept edge (cycle 1 = ACCESS).
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata, output logic fault,
                       output logic [3:0] wen_seen, output int wen_cycles,
                       output logic [15:0] addr_seen, output int ready_hi, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    rdata = 32'd0; fault = 1'b0; wen_seen = 4'd0; wen_cycles = 0; addr_seen = 16'd0;
    ready_hi = 0; lat = -1;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clk);
      if (c == 1) addr_seen = mem_address;
      if (req_ready) ready_hi++;
      if (mem_w_en != 4'd0) begin wen_cycles++; wen_seen |= mem_w_en; end
      if (rsp_valid) begin lat = c; rdata = rsp_rdata; fault = rsp_fault; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1;
    #3;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset req_ready: got %0b want 1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset rsp_valid: got %0b want 0", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset rsp_rdata: got %h want 0", rsp_rdata); end
    n_cmp++; if (rsp_fault !== 1'b0) begin n_fail++; $display("FAIL reset rsp_fault: got %0b want 0", rsp_fault); end
    n_cmp++; if (mem_w_en !== 4'd0) begin n_fail++; $display("FAIL reset mem_w_en: got %b want 0000", mem_w_en); end
    n_cmp++; if (mem_address !== 16'd0) begin n_fail++; $display("FAIL reset mem_address: got %h want 0", mem_address); end
    n_cmp++; if (mem_write_data !== 32'd0) begin n_fail++; $display("FAIL reset mem_write_data: got %h want 0", mem_write_data); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_fault;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_wen;
  } vec_t;

  task automatic test_directed();
    vec_t v [14];
    logic [31:0] rd; logic flt; logic [3:0] ws; int wc; logic [15:0] as; int rh; int lat;
    logic mf; logic [31:0] mr; logic [3:0] mw;
    v[0]  = '{1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 4'b1111};
    v[1]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,         1'b0, 32'hDEAD_BEEF, 4'b0000};
    v[2]  = '{1'b1, 3'b000, 32'h0000_0201, 32'h0000_0080, 1'b0, 32'h0000_0000, 4'b0001};
    v[3]  = '{1'b0, 3'b000, 32'h0000_0201, 32'h0,         1'b0, 32'hFFFF_FF80, 4'b0000};
    v[4]  = '{1'b0, 3'b100, 32'h0000_0201, 32'h0,         1'b0, 32'h0000_0080, 4'b0000};
    v[5]  = '{1'b1, 3'b001, 32'h0000_0300, 32'h0000_8001, 1'b0, 32'h0000_0000, 4'b0011};
    v[6]  = '{1'b0, 3'b001, 32'h0000_0300, 32'h0,         1'b0, 32'hFFFF_8001, 4'b0000};
    v[7]  = '{1'b0, 3'b101, 32'h0000_0300, 32'h0,         1'b0, 32'h0000_8001, 4'b0000};
    v[8]  = '{1'b0, 3'b010, 32'h0000_0102, 32'h0,         1'b1, 32'h0000_0000, 4'b0000};
    v[9]  = '{1'b1, 3'b010, 32'h0001_0000, 32'h1234_5678, 1'b1, 32'h0000_0000, 4'b0000};
    v[10] = '{1'b1, 3'b100, 32'h0000_0500, 32'h1111_1111, 1'b1, 32'h0000_0000, 4'b0000};
    v[11] = '{1'b0, 3'b011, 32'h0000_0500, 32'h0,         1'b1, 32'h0000_0000, 4'b0000};
    v[12] = '{1'b1, 3'b001, 32'h0000_0301, 32'h0000_7777, 1'b1, 32'h0000_0000, 4'b0000};
    v[13] = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,         1'b0, 32'hDEAD_BEEF, 4'b0000};
    for (int i = 0; i < 14; i++) begin
      model_txn(v[i].we, v[i].f3, v[i].addr, v[i].wdata, mf, mr, mw);
      issue(v[i].we, v[i].f3, v[i].addr, v[i].wdata, rd, flt, ws, wc, as, rh, lat);
      n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL directed[%0d] latency: got %0d want 2", i, lat); end
      n_cmp++; if (flt !== v[i].exp_fault) begin n_fail++; $display("FAIL directed[%0d] fault: got %0b want %0b", i, flt, v[i].exp_fault); end
      n_cmp++; if (rd !== v[i].exp_rdata) begin n_fail++; $display("FAIL directed[%0d] rdata: got %h want %h", i, rd, v[i].exp_rdata); end
      n_cmp++; if (ws !== v[i].exp_wen) begin n_fail++; $display("FAIL directed[%0d] mem_w_en: got %b want %b", i, ws, v[i].exp_wen); end
      n_cmp++; if (wc !== ((v[i].exp_wen != 4'd0) ? 1 : 0)) begin n_fail++; $display("FAIL directed[%0d] strobe cycles: got %0d want %0d", i, wc, (v[i].exp_wen != 4'd0) ? 1 : 0); end
      n_cmp++; if (as !== v[i].addr[15:0]) begin n_fail++; $display("FAIL directed[%0d] mem_address: got %h want %h", i, as, v[i].addr[15:0]); end
      n_cmp++; if (rh !== 0) begin n_fail++; $display("FAIL directed[%0d] req_ready while busy: got %0d cycles want 0", i, rh); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic flt; logic [3:0] ws; int wc; logic [15:0] as; int rh; int lat;
    logic mf; logic [31:0] mr; logic [3:0] mw;
    model_txn(1'b0, 3'b010, 32'h100, 32'h0, mf, mr, mw);
    rsp_ready = 1'b0;
    issue(1'b0, 3'b010, 32'h100, 32'h0, rd, flt, ws, wc, as, rh, lat);
    n_cmp++; if (rd !== mr) begin n_fail++; $display("FAIL backpressure first rdata: got %h want %h", rd, mr); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL backpressure hold%0d rsp_valid: got %0b want 1", c, rsp_valid); end
      n_cmp++; if (rsp_rdata !== mr) begin n_fail++; $display("FAIL backpressure hold%0d rsp_rdata: got %h want %h", c, rsp_rdata, mr); end
      n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL backpressure hold%0d req_ready: got %0b want 0", c, req_ready); end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL backpressure release rsp_valid: got %0b want 0", rsp_valid); end
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL backpressure release req_ready: got %0b want 1", req_ready); end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd; logic flt; logic [3:0] ws; int wc; logic [15:0] as; int rh; int lat;
    logic mf; logic [31:0] mr; logic [3:0] mw;
    model_txn(1'b1, 3'b010, 32'h400, 32'h1122_3344, mf, mr, mw);
    issue(1'b1, 3'b010, 32'h400, 32'h1122_3344, rd, flt, ws, wc, as, rh, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h400; req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_cmp++; if (mem_w_en !== 4'b1111) begin n_fail++; $display("FAIL midreset access strobe: got %b want 1111", mem_w_en); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (mem_w_en !== 4'd0) begin n_fail++; $display("FAIL midreset mem_w_en: got %b want 0000", mem_w_en); end
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midreset req_ready: got %0b want 1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0 || rsp_fault !== 1'b0 || rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL midreset rsp: got v=%0b f=%0b d=%h want 0/0/0", rsp_valid, rsp_fault, rsp_rdata); end
    n_cmp++; if (mem_address !== 16'd0 || mem_write_data !== 32'd0) begin n_fail++; $display("FAIL midreset mem bus: got a=%h d=%h want 0/0", mem_address, mem_write_data); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_txn(1'b0, 3'b010, 32'h400, 32'h0, mf, mr, mw);
    issue(1'b0, 3'b010, 32'h400, 32'h0, rd, flt, ws, wc, as, rh, lat);
    n_cmp++; if (rd !== mr || flt !== 1'b0) begin n_fail++; $display("FAIL midreset readback: got %h f=%0b want %h f=0", rd, flt, mr); end
  endtask

  task automatic test_random();
    logic we; logic [2:0] f3; logic [31:0] addr; logic [31:0] wdata;
    logic [31:0] rd; logic flt; logic [3:0] ws; int wc; logic [15:0] as; int rh; int lat;
    logic mf; logic [31:0] mr; logic [3:0] mw;
    logic [2:0] ld_f3 [5];
    ld_f3[0] = 3'd0; ld_f3[1] = 3'd1; ld_f3[2] = 3'd2; ld_f3[3] = 3'd4; ld_f3[4] = 3'd5;
    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
      else f3 = we ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
      addr = 32'h800 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) addr = addr | (32'd1 << $urandom_range(16, 31));
      if ($urandom_range(0, 19) == 0) addr = 32'h0000_FFFC + 32'($urandom_range(0, 3));
      wdata = $urandom;
      model_txn(we, f3, addr, wdata, mf, mr, mw);
      issue(we, f3, addr, wdata, rd, flt, ws, wc, as, rh, lat);
      n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL random[%0d] latency: got %0d want 2", i, lat); end
      n_cmp++; if (flt !== mf) begin n_fail++; $display("FAIL random[%0d] fault we=%0b f3=%0d a=%h: got %0b want %0b", i, we, f3, addr, flt, mf); end
      n_cmp++; if (rd !== mr) begin n_fail++; $display("FAIL random[%0d] rdata we=%0b f3=%0d a=%h: got %h want %h", i, we, f3, addr, rd, mr); end
      n_cmp++; if (ws !== mw || wc !== ((mw != 4'd0) ? 1 : 0)) begin n_fail++; $display("FAIL random[%0d] strobe: got %b x%0d want %b", i, ws, wc, mw); end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] b;
    n_cmp = 0;
    n_fail = 0;
    for (int i = 0; i < 65536; i++) begin
      b = 8'($urandom);
      sram[i] <= b;
      ref_mem[i] = b;
    end
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_access();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_sram_if.md
Name: lsu_sram_if

Overview:
Load/store unit sitting directly upstream of the byte-addressed data SRAM. It accepts one memory request at a time from the core over a valid/ready handshake and decodes RISC-V funct3 into the SRAM's 4-bit write strobe. It checks alignment and range, sign- or zero-extends load data, and returns a registered response over a second valid/ready handshake.

Parameters:
ADDR_W, 16, SRAM byte-address width; core addresses with any bit set at or above ADDR_W fault.
CHECK_ALIGN, 1, 1 = halfword/word accesses must be naturally aligned; 0 = misalignment allowed, and the SRAM wraps bytes modulo 2^ADDR_W.

Ports:
clk  in  1  single clock; all state updates on posedge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  core request valid
req_ready  out  1  LSU can accept a request
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V width/sign code
req_addr  in  32  byte address (ALU result)
req_wdata  in  32  store data, LSB-justified
rsp_valid  out  1  response valid
rsp_ready  in  1  core accepts the response
rsp_rdata  out  32  extended load data (0 for stores and faults)
rsp_fault  out  1  access was rejected
mem_w_en  out  4  SRAM strobe: 0001 = sb, 0011 = sh, 1111 = sw, 0000 = none
mem_address  out  ADDR_W  SRAM byte address
mem_write_data  out  32  SRAM write data
mem_read_data  in  32  SRAM combinational read: bytes at address..address+3, little-endian

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_fault=0, mem_w_en=0000, mem_address=0, mem_write_data=0, and all internal request registers 0.
- req_ready = (state==IDLE). This is combinational from state only, never from req_valid.
- IDLE, when req_valid & req_ready:
  - latch we, funct3, addr[ADDR_W-1:0] and wdata;
  - compute fault;
  - go to ACCESS.
- Fault conditions (any one is sufficient):
  - addr[31:ADDR_W] != 0;
  - illegal funct3: stores allow only 000/001/010; loads allow only 000/001/010/100/101;
  - CHECK_ALIGN=1 and either halfword with addr[0]=1, or word with addr[1:0]!=0.
- ACCESS (exactly 1 cycle):
  - mem_address and mem_write_data driven from the latched registers;
  - mem_w_en driven per funct3 only if we=1 and no fault, otherwise 0000;
  - the SRAM commits the write at the end of this cycle;
  - for a non-faulting load, rsp_rdata is registered from mem_read_data at the end of ACCESS:
    - lb: sign-extend [7:0]; lbu: zero-extend [7:0];
    - lh: sign-extend [15:0]; lhu: zero-extend [15:0];
    - lw: [31:0].
  - rsp_fault is registered at the same edge; rsp_rdata is 0 for stores and faults.
  - Go to RESP.
- mem_w_en must be registered or decoded from state so that it is non-zero only during ACCESS. It must never glitch to a non-zero value in IDLE or RESP.
- mem_address and mem_write_data hold their last value outside ACCESS.
- RESP:
  - rsp_valid=1, with rsp_rdata and rsp_fault stable while rsp_valid=1 and rsp_ready=0;
  - on rsp_ready, return to IDLE and drop rsp_valid the next cycle.
  - rsp_ready is ignored outside RESP.
- Latency: request accepted at edge N; strobe asserted in cycle N+1; rsp_valid=1 from cycle N+2. Minimum issue interval is 3 cycles, with no overlap between requests.
- Faulting accesses follow the same timing with no SRAM write.
- Reset mid-operation: rst_n low immediately forces IDLE and the reset values. mem_w_en drops asynchronously and the pending write is abandoned.
- Wrap-around: with CHECK_ALIGN=0, a word at 0xFFFE writes bytes 0xFFFE, 0xFFFF, 0x0000, 0x0001. This is SRAM modulo behaviour and is not a fault.

Decomposition:
- Shared package: funct3 constants (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101), strobe constants (WEN_NONE/B/H/W), and the FSM state enum.
- One sub-module, lsu_load_ext: combinational funct3 + 32-bit raw data -> 32-bit extended data.

Test Plan:
- sw addr=0x100 data=0xDEADBEEF, then lw 0x100 -> mem_w_en=1111 for exactly 1 cycle; lw returns 0xDEADBEEF with rsp_fault=0; rsp_valid 2 cycles after acceptance.
- sb 0x201 data=0x80, then lb 0x201 and lbu 0x201 -> mem_w_en=0001; returns 0xFFFFFF80 and 0x00000080.
- sh 0x300 data=0x8001, then lh/lhu 0x300 -> 0xFFFF8001 and 0x00008001.
- Faults:
  - lw 0x102 (CHECK_ALIGN=1) -> rsp_fault=1, rdata=0;
  - sw 0x00010000 -> fault and mem_w_en stays 0000;
  - store funct3=100 -> fault.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata and req_ready=0 stay stable; release -> IDLE and req_ready=1 next cycle.
- Assert rst_n=0 during the ACCESS cycle of sw 0x400 -> mem_w_en=0000 immediately, no write (a later lw 0x400 returns the prior value), and all outputs return to reset values.
